// File: rtl/motoro301_uart_rx_cmd_if.sv
// Receiver/decoder output bundle: received byte, framing status and motor command strobes/levels.
interface motoro301_uart_rx_cmd_if;
   logic [7:0] rxDataO;
   logic       rxValidO;
   logic       rxFrameErrO;
   logic       m3startO;
   logic       m3forceStopO;
   logic       m3invRotateO;
   logic       m3freqINCo;
   logic       m3freqDECo;
   logic       cmdUnknownO;

   // Driven by the receiver.
   modport master (
      output rxDataO, rxValidO, rxFrameErrO,
      output m3startO, m3forceStopO, m3invRotateO,
      output m3freqINCo, m3freqDECo, cmdUnknownO
   );

   // Consumed by the motor-control logic (OR-ed with the button paths).
   modport slave (
      input rxDataO, rxValidO, rxFrameErrO,
      input m3startO, m3forceStopO, m3invRotateO,
      input m3freqINCo, m3freqDECo, cmdUnknownO
   );
endinterface

// File: rtl/motoro301_uart_rx_cmd.sv
// UART 8N1 receiver with a single-character motor command decoder.
// Bytes are sampled mid-bit, LSB first; a low stop bit parks the FSM until the line returns high.
module motoro301_uart_rx_cmd #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic                          clk50mhzI,
   input  logic                          resetI,
   input  logic                          uRxI,
   motoro301_uart_rx_cmd_if.master       o_cmd
);

   localparam int unsigned DIV   = CLK_HZ / BAUD;
   localparam int unsigned HALF  = DIV / 2;
   localparam int unsigned CNT_W = $clog2(DIV);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e             r_state, w_state_d;
   logic               r_rx_meta, r_rx_s;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic [2:0]         r_bit_idx, w_bit_idx_d;
   logic [7:0]         r_sh, w_sh_d;
   logic [7:0]         r_rx_data, w_rx_data_d;
   logic               r_rx_valid, w_rx_valid_d;
   logic               r_frame_err, w_frame_err_d;

   logic               r_start, w_start_d;
   logic               r_inv, w_inv_d;
   logic               r_force_stop, w_force_stop_d;
   logic               r_inc, w_inc_d;
   logic               r_dec, w_dec_d;
   logic               r_unknown, w_unknown_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         r_rx_meta <= 1'b1;
         r_rx_s    <= 1'b1;
      end else begin
         r_rx_meta <= uRxI;
         r_rx_s    <= r_rx_meta;
      end
   end

   // FSM state register.
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (!r_rx_s) w_state_d = StStart;
         StStart: if (r_cnt == CNT_HALF) w_state_d = r_rx_s ? StIdle : StData;
         StData:  if (r_cnt == CNT_LAST && r_bit_idx == 3'd7) w_state_d = StStop;
         StStop:  if (r_cnt == CNT_LAST) w_state_d = r_rx_s ? StIdle : StBreak;
         StBreak: if (r_rx_s) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // FSM datapath/outputs: bit timing counter, shift register and frame result pulses.
   always_comb begin
      w_cnt_d       = r_cnt;
      w_bit_idx_d   = r_bit_idx;
      w_sh_d        = r_sh;
      w_rx_data_d   = r_rx_data;
      w_rx_valid_d  = 1'b0;
      w_frame_err_d = 1'b0;
      case (r_state)
         StIdle: begin
            w_cnt_d = '0;
         end
         StStart: begin
            if (r_cnt == CNT_HALF) begin
               w_cnt_d     = '0;
               w_bit_idx_d = 3'd0;
            end else begin
               w_cnt_d = r_cnt + CNT_ONE;
            end
         end
         StData: begin
            if (r_cnt == CNT_LAST) begin
               w_sh_d      = {r_rx_s, r_sh[7:1]};
               w_cnt_d     = '0;
               w_bit_idx_d = r_bit_idx + 3'd1;
            end else begin
               w_cnt_d = r_cnt + CNT_ONE;
            end
         end
         StStop: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt_d = '0;
               if (r_rx_s) begin
                  w_rx_data_d  = r_sh;
                  w_rx_valid_d = 1'b1;
               end else begin
                  w_frame_err_d = 1'b1;
               end
            end else begin
               w_cnt_d = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_cnt_d = '0;
         end
      endcase
   end

   // Receiver datapath registers.
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         r_cnt       <= '0;
         r_bit_idx   <= 3'd0;
         r_sh        <= 8'h00;
         r_rx_data   <= 8'h00;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_d;
         r_bit_idx   <= w_bit_idx_d;
         r_sh        <= w_sh_d;
         r_rx_data   <= w_rx_data_d;
         r_rx_valid  <= w_rx_valid_d;
         r_frame_err <= w_frame_err_d;
      end
   end

   // Command decode of the byte presented with rxValidO; levels hold unless a command moves them.
   always_comb begin
      w_start_d      = r_start;
      w_inv_d        = r_inv;
      w_force_stop_d = 1'b0;
      w_inc_d        = 1'b0;
      w_dec_d        = 1'b0;
      w_unknown_d    = 1'b0;
      if (r_rx_valid) begin
         case (r_rx_data)
            8'h53: w_start_d = 1'b1;
            8'h58: begin
               w_start_d      = 1'b0;
               w_force_stop_d = 1'b1;
            end
            8'h52: w_inv_d = ~r_inv;
            8'h2B: w_inc_d = 1'b1;
            8'h2D: w_dec_d = 1'b1;
            default: w_unknown_d = 1'b1;
         endcase
      end
   end

   // Decoder output registers.
   always_ff @(posedge clk50mhzI) begin
      if (resetI) begin
         r_start      <= 1'b0;
         r_inv        <= 1'b0;
         r_force_stop <= 1'b0;
         r_inc        <= 1'b0;
         r_dec        <= 1'b0;
         r_unknown    <= 1'b0;
      end else begin
         r_start      <= w_start_d;
         r_inv        <= w_inv_d;
         r_force_stop <= w_force_stop_d;
         r_inc        <= w_inc_d;
         r_dec        <= w_dec_d;
         r_unknown    <= w_unknown_d;
      end
   end

   assign o_cmd.rxDataO      = r_rx_data;
   assign o_cmd.rxValidO     = r_rx_valid;
   assign o_cmd.rxFrameErrO  = r_frame_err;
   assign o_cmd.m3startO     = r_start;
   assign o_cmd.m3forceStopO = r_force_stop;
   assign o_cmd.m3invRotateO = r_inv;
   assign o_cmd.m3freqINCo   = r_inc;
   assign o_cmd.m3freqDECo   = r_dec;
   assign o_cmd.cmdUnknownO  = r_unknown;

endmodule
